// File: rtl/rv32e_mem_arbiter_if.sv
// Bus bundle between N_REQ cores, the memory arbiter and the shared data RAM.
// The arbiter takes the slave modport; the core/RAM side takes master.
interface rv32e_mem_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_wdata;
  logic [N_REQ-1:0]    req_write;
  logic [N_REQ-1:0]    req_ack;
  logic [N_REQ-1:0]    req_stall;
  logic [DW-1:0]       req_rdata;
  logic [AW-1:0]       mem_addr_bus;
  logic [DW-1:0]       mem_write_data_bus;
  logic                mem_write_signal;
  logic [DW-1:0]       mem_read_data_bus;

  modport slave (
    input  req_valid, req_addr, req_wdata, req_write, mem_read_data_bus,
    output req_ack, req_stall, req_rdata,
           mem_addr_bus, mem_write_data_bus, mem_write_signal
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_write, mem_read_data_bus,
    input  req_ack, req_stall, req_rdata,
           mem_addr_bus, mem_write_data_bus, mem_write_signal
  );
endinterface

// File: rtl/rv32e_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM among N_REQ cores.
// Each access takes IDLE -> ISSUE -> DONE, acked one cycle after DONE.
module rv32e_mem_arbiter #(
  parameter int N_REQ = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  rv32e_mem_arbiter_if.slave   bus
);

  localparam int          IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned NU = N_REQ;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [IW-1:0]   last_grant, winner, pick, cand;
  logic            pick_found;
  logic [AW-1:0]   lat_addr;
  logic [DW-1:0]   lat_wdata;
  logic            lat_write;
  logic [N_REQ-1:0] ack;
  logic [DW-1:0]   rdata;

  // Search starts one past the last winner so every core gets a turn.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int unsigned k = 1; k <= NU; k++) begin
      cand = IW'((32'(last_grant) + k) % NU);
      if (!pick_found && bus.req_valid[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_found) state_next = ISSUE;
      ISSUE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ack            = ack;
    bus.req_rdata          = rdata;
    bus.req_stall          = bus.req_valid & ~ack;
    bus.mem_addr_bus       = '0;
    bus.mem_write_data_bus = '0;
    bus.mem_write_signal   = 1'b0;
    case (state)
      ISSUE: begin
        bus.mem_addr_bus       = lat_addr;
        bus.mem_write_data_bus = lat_wdata;
        // Gated by reset so a store aborted mid-ISSUE never reaches the RAM.
        bus.mem_write_signal   = lat_write & reset;
      end
      DONE: begin
        bus.mem_addr_bus       = lat_addr;
        bus.mem_write_data_bus = lat_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= IW'(N_REQ - 1);
      winner     <= '0;
      ack        <= '0;
      rdata      <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_write  <= 1'b0;
    end else begin
      state <= state_next;
      ack   <= '0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            winner    <= pick;
            lat_addr  <= bus.req_addr[32'(pick)*AW +: AW];
            lat_wdata <= bus.req_wdata[32'(pick)*DW +: DW];
            lat_write <= bus.req_write[pick];
          end
        end
        DONE: begin
          rdata       <= bus.mem_read_data_bus;
          ack[winner] <= 1'b1;
          last_grant  <= winner;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rv32e_mem_arbiter.md
RV32E_MEM_ARBITER -- requirements
Module: rv32e_mem_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2: number of requesting cores (2..8).
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter DW, default 32: data width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  N_REQ  per-core access request, bit i = core i.
REQ-007 SHALL have port req_addr  input  N_REQ*AW  per-core address; core i at slice [i*AW +: AW].
REQ-008 SHALL have port req_wdata  input  N_REQ*DW  per-core write data; slice [i*DW +: DW].
REQ-009 SHALL have port req_write  input  N_REQ  per-core write enable (1 = store, 0 = load).
REQ-010 SHALL have port req_ack  output  N_REQ  one-cycle completion pulse per core.
REQ-011 SHALL have port req_stall  output  N_REQ  per-core stall; core i freezes while high.
REQ-012 SHALL have port req_rdata  output  DW  registered read data, valid in the req_ack cycle.
REQ-013 SHALL have port mem_addr_bus  output  AW  shared data-RAM address.
REQ-014 SHALL have port mem_write_data_bus  output  DW  shared data-RAM write data.
REQ-015 SHALL have port mem_write_signal  output  1  shared data-RAM write strobe.
REQ-016 SHALL have port mem_read_data_bus  input  DW  shared data-RAM read data, valid one cycle after address.

Function
REQ-017 SHALL implement a three-state FSM: IDLE, ISSUE, DONE.
REQ-018 IDLE: if any req_valid bit is high, SHALL select a winner, latch its addr/wdata/write/index, and go to ISSUE; otherwise stay in IDLE.
REQ-019 Winner selection SHALL be round-robin: first set req_valid bit searching from (last_grant+1) mod N_REQ upward, wrapping.
REQ-020 ISSUE: SHALL drive mem_addr_bus, mem_write_data_bus from latched values; mem_write_signal = latched write; SHALL go to DONE.
REQ-021 DONE: SHALL keep mem_addr_bus at the latched address, mem_write_signal 0; SHALL capture mem_read_data_bus into req_rdata; SHALL set req_ack[winner] high for the next cycle only; last_grant <= winner; go to IDLE.
REQ-022 mem_write_signal SHALL be high only in ISSUE, for exactly one cycle per store; never in IDLE or DONE.
REQ-023 In IDLE, mem_addr_bus, mem_write_data_bus and mem_write_signal SHALL be 0.
REQ-024 req_stall[i] SHALL equal req_valid[i] AND NOT req_ack[i] (combinational); a core sees stall low in its ack cycle.
REQ-025 Latency SHALL be: request in IDLE at cycle T -> req_ack at cycle T+3; peak throughput one access per 3 cycles.
REQ-026 Requester SHALL hold req_valid/addr/wdata/write stable until ack; arbiter SHALL use only latched values after IDLE, so changes or req_valid drop after latch SHALL NOT alter the in-flight access, and ack is still pulsed.
REQ-027 A core re-requesting in its ack cycle SHALL be arbitrated normally from IDLE on the next cycle; round-robin SHALL give others priority.
REQ-028 With one requester continuously active, it SHALL be granted every 3 cycles with no idle gap.
REQ-029 req_rdata SHALL hold its last value between captures; for stores it SHALL capture whatever the RAM returns (don't-care for the core).

Reset
REQ-030 While reset is low at a clock edge: FSM SHALL go to IDLE, last_grant SHALL be N_REQ-1 (core 0 wins first), req_ack SHALL be 0, req_rdata SHALL be 0, latched registers SHALL be 0.
REQ-031 mem_write_signal SHALL be gated by reset high, so no store reaches RAM during any cycle with reset low, including reset asserted in ISSUE; the aborted access SHALL receive no ack.

Verification
REQ-032 Reset, then core0 load addr 0x10 (RAM holds 0xDEADBEEF) -> req_ack[0] at T+3, req_rdata 0xDEADBEEF, mem_write_signal never high.
REQ-033 Core1 store 0x55 to addr 0x08 -> mem_write_signal high exactly one cycle at T+1 with mem_addr_bus 0x08, mem_write_data_bus 0x55; ack[1] at T+3; subsequent load of 0x08 returns 0x55.
REQ-034 Both cores request continuously from reset -> grant order 0,1,0,1 with acks every 3 cycles, alternating.
REQ-035 Core0 drops req_valid and changes addr the cycle after latch -> original address still issued, ack[0] still pulsed once.
REQ-036 Reset low during ISSUE of a store to 0x20 -> no write strobe, no ack, FSM in IDLE, RAM[0x20] unchanged.
REQ-037 N_REQ=4, requests on cores 1 and 3 after last_grant=1 -> core 3 served before core 1.
